// File: rtl/mac2x2_seq_ctrl.sv
// mac2x2_seq_ctrl
// Sequencer that sits in front of a 2x2 MAC array. It accepts K operand beats
// (one column of A and one row of B per beat), issues each beat to the array,
// and feeds the array's results back as the accumulator inputs of the next
// beat. After the beat flagged s_last it presents the final 2x2 tile
// C = A*B on a valid/ready result port. Only one beat is ever in flight: the
// next beat is issued only after the array's out_valid for the current one,
// so any fixed array latency L >= 1 is tolerated (beat period = 2 + L).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_valid/s_ready       operand beat handshake; s_last marks beat K-1
//   s_a0/s_a1, s_b0/s_b1  A[0][k], A[1][k], B[k][0], B[k][1]
//   mac_in_valid          one-cycle issue pulse to the array
//   mac_a*/mac_b*         operands to the array (held until the next issue)
//   mac_acc**             accumulator inputs to the array
//   mac_out_valid, mac_y** array result strobe and results
//   res_valid/res_ready   final tile handshake; res_c** is the tile
//   beat_cnt              beats completed in the current tile (saturating)
//   err_stray             sticky: mac_out_valid seen while not waiting on one
module mac2x2_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    input  logic [DATA_W-1:0] s_a0,
    input  logic [DATA_W-1:0] s_a1,
    input  logic [DATA_W-1:0] s_b0,
    input  logic [DATA_W-1:0] s_b1,

    output logic              mac_in_valid,
    output logic [DATA_W-1:0] mac_a0,
    output logic [DATA_W-1:0] mac_a1,
    output logic [DATA_W-1:0] mac_b0,
    output logic [DATA_W-1:0] mac_b1,
    output logic [ACC_W-1:0]  mac_acc00,
    output logic [ACC_W-1:0]  mac_acc01,
    output logic [ACC_W-1:0]  mac_acc10,
    output logic [ACC_W-1:0]  mac_acc11,

    input  logic              mac_out_valid,
    input  logic [ACC_W-1:0]  mac_y00,
    input  logic [ACC_W-1:0]  mac_y01,
    input  logic [ACC_W-1:0]  mac_y10,
    input  logic [ACC_W-1:0]  mac_y11,

    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_c00,
    output logic [ACC_W-1:0]  res_c01,
    output logic [ACC_W-1:0]  res_c10,
    output logic [ACC_W-1:0]  res_c11,

    output logic [CNT_W-1:0]  beat_cnt,
    output logic              err_stray
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Beat operand registers: loaded on the input handshake and left alone
    // until the next one, so the array sees stable operands through WAIT.
    logic [DATA_W-1:0] a0_r, a1_r, b0_r, b1_r;
    logic              last_r;

    // Running accumulator; doubles as the final result tile.
    logic [ACC_W-1:0]  acc00_r, acc01_r, acc10_r, acc11_r;

    logic [CNT_W-1:0]  cnt_r;
    logic              stray_r;

    logic              beat_take;
    logic              res_take;
    logic              first_beat;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Next state and decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        s_ready      = 1'b0;
        mac_in_valid = 1'b0;
        res_valid    = 1'b0;
        case (state)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                mac_in_valid = 1'b1;
                state_nxt    = WAIT;
            end
            WAIT: begin
                if (mac_out_valid) state_nxt = last_r ? DONE : IDLE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign beat_take  = (state == IDLE) && s_valid;
    assign res_take   = (state == DONE) && res_ready;
    // The count is cleared when a tile's result is taken, so zero means the
    // beat being issued opens a new tile and must start from a zero
    // accumulator rather than whatever the previous tile left behind.
    assign first_beat = (cnt_r == '0);

    // ------------------------------------------------------------------
    // Operand capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a0_r   <= '0;
            a1_r   <= '0;
            b0_r   <= '0;
            b1_r   <= '0;
            last_r <= 1'b0;
        end else if (beat_take) begin
            a0_r   <= s_a0;
            a1_r   <= s_a1;
            b0_r   <= s_b0;
            b1_r   <= s_b1;
            last_r <= s_last;
        end
    end

    // ------------------------------------------------------------------
    // Accumulator capture from the array; only a result arriving in WAIT
    // belongs to the beat in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc00_r <= '0;
            acc01_r <= '0;
            acc10_r <= '0;
            acc11_r <= '0;
        end else if ((state == WAIT) && mac_out_valid) begin
            acc00_r <= mac_y00;
            acc01_r <= mac_y01;
            acc10_r <= mac_y10;
            acc11_r <= mac_y11;
        end
    end

    // ------------------------------------------------------------------
    // Beat counter: saturates at all-ones, cleared when the tile is taken.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (res_take) begin
            cnt_r <= '0;
        end else if ((state == WAIT) && mac_out_valid && (cnt_r != '1)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Sticky error for array results that arrive when none is expected.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              stray_r <= 1'b0;
        else if (mac_out_valid && state != WAIT) stray_r <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Array-side outputs. The accumulator feed is a pure function of held
    // registers, so it is stable across ISSUE and WAIT for free.
    // ------------------------------------------------------------------
    assign mac_a0    = a0_r;
    assign mac_a1    = a1_r;
    assign mac_b0    = b0_r;
    assign mac_b1    = b1_r;
    assign mac_acc00 = first_beat ? '0 : acc00_r;
    assign mac_acc01 = first_beat ? '0 : acc01_r;
    assign mac_acc10 = first_beat ? '0 : acc10_r;
    assign mac_acc11 = first_beat ? '0 : acc11_r;

    assign res_c00   = acc00_r;
    assign res_c01   = acc01_r;
    assign res_c10   = acc10_r;
    assign res_c11   = acc11_r;

    assign beat_cnt  = cnt_r;
    assign err_stray = stray_r;

endmodule

// File: tb/tb_mac2x2_seq_ctrl.sv
// Directed bench for mac2x2_seq_ctrl. A small behavioural 2x2 MAC with a
// fixed latency stands in for the array; expected tiles are hand-computed.
module tb_mac2x2_seq_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s_valid = 1'b0, s_ready, s_last = 1'b0;
    logic [7:0]  s_a0 = '0, s_a1 = '0, s_b0 = '0, s_b1 = '0;
    logic        mac_in_valid;
    logic [7:0]  mac_a0, mac_a1, mac_b0, mac_b1;
    logic [31:0] mac_acc00, mac_acc01, mac_acc10, mac_acc11;
    logic        mac_out_valid;
    logic [31:0] mac_y00, mac_y01, mac_y10, mac_y11;
    logic        res_valid, res_ready = 1'b0;
    logic [31:0] res_c00, res_c01, res_c10, res_c11;
    logic [15:0] beat_cnt;
    logic        err_stray;
    logic        stray = 1'b0;

    mac2x2_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .s_a0(s_a0), .s_a1(s_a1), .s_b0(s_b0), .s_b1(s_b1),
        .mac_in_valid(mac_in_valid),
        .mac_a0(mac_a0), .mac_a1(mac_a1), .mac_b0(mac_b0), .mac_b1(mac_b1),
        .mac_acc00(mac_acc00), .mac_acc01(mac_acc01),
        .mac_acc10(mac_acc10), .mac_acc11(mac_acc11),
        .mac_out_valid(mac_out_valid),
        .mac_y00(mac_y00), .mac_y01(mac_y01), .mac_y10(mac_y10), .mac_y11(mac_y11),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_c00(res_c00), .res_c01(res_c01), .res_c10(res_c10), .res_c11(res_c11),
        .beat_cnt(beat_cnt), .err_stray(err_stray)
    );

    // Behavioural array: y = acc + a*b (signed), LAT cycles after issue.
    logic [LAT-1:0] mv;
    logic [31:0]    my [LAT][4];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv <= '0;
        end else begin
            mv <= {mv[LAT-2:0], mac_in_valid};
            my[0][0] <= $signed(mac_acc00) + $signed(mac_a0) * $signed(mac_b0);
            my[0][1] <= $signed(mac_acc01) + $signed(mac_a0) * $signed(mac_b1);
            my[0][2] <= $signed(mac_acc10) + $signed(mac_a1) * $signed(mac_b0);
            my[0][3] <= $signed(mac_acc11) + $signed(mac_a1) * $signed(mac_b1);
            for (int i = 1; i < LAT; i++)
                for (int j = 0; j < 4; j++) my[i][j] <= my[i-1][j];
        end
    end
    assign mac_out_valid = mv[LAT-1] | stray;
    assign mac_y00 = my[LAT-1][0];
    assign mac_y01 = my[LAT-1][1];
    assign mac_y10 = my[LAT-1][2];
    assign mac_y11 = my[LAT-1][3];

    typedef struct packed {
        logic [2:0]        k;
        logic [3:0][7:0]   a0, a1, b0, b1;   // index = beat number
        logic [3:0][31:0]  c;                // c00, c01, c10, c11 at [0..3]
        logic [7:0]        bp;               // cycles of res_ready=0
    } vec_t;

    vec_t vt [5];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, $signed(act), $signed(exp));
        end
    endtask

    // Present one beat, wait for the handshake, then check the ISSUE cycle.
    task automatic send_beat(input logic [7:0] a0, input logic [7:0] a1,
                             input logic [7:0] b0, input logic [7:0] b1,
                             input logic last, input logic first);
        bit ok = 0;
        s_valid = 1'b1; s_last = last;
        s_a0 = a0; s_a1 = a1; s_b0 = b0; s_b1 = b1;
        for (int cy = 0; cy < 200 && !ok; cy++) begin
            if (s_ready) begin
                @(posedge clk);
                ok = 1;
            end else begin
                @(negedge clk);
            end
        end
        chk("beat_accept", {31'd0, ok}, 32'd1);
        #1 s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        chk("issue_valid", {31'd0, mac_in_valid}, 32'd1);
        chk("issue_ready", {31'd0, s_ready}, 32'd0);
        chk("issue_a0", {24'd0, mac_a0}, {24'd0, a0});
        chk("issue_a1", {24'd0, mac_a1}, {24'd0, a1});
        chk("issue_b0", {24'd0, mac_b0}, {24'd0, b0});
        chk("issue_b1", {24'd0, mac_b1}, {24'd0, b1});
        if (first) begin
            chk("first_acc00", mac_acc00, 32'd0);
            chk("first_acc01", mac_acc01, 32'd0);
            chk("first_acc10", mac_acc10, 32'd0);
            chk("first_acc11", mac_acc11, 32'd0);
        end
    endtask

    task automatic run_tile(input vec_t v);
        int cy = 0;
        for (int k = 0; k < int'(v.k); k++)
            send_beat(v.a0[k], v.a1[k], v.b0[k], v.b1[k], k == int'(v.k) - 1, k == 0);
        while (!res_valid && cy < 200) begin
            @(negedge clk);
            cy++;
        end
        chk("res_valid", {31'd0, res_valid}, 32'd1);
        chk("res_beat_cnt", {16'd0, beat_cnt}, {29'd0, v.k});
        chk("res_c00", res_c00, v.c[0]);
        chk("res_c01", res_c01, v.c[1]);
        chk("res_c10", res_c10, v.c[2]);
        chk("res_c11", res_c11, v.c[3]);
        for (int i = 0; i < int'(v.bp); i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, res_valid}, 32'd1);
            chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
            chk("bp_c00", res_c00, v.c[0]);
            chk("bp_c11", res_c11, v.c[3]);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        chk("post_valid", {31'd0, res_valid}, 32'd0);
        chk("post_s_ready", {31'd0, s_ready}, 32'd1);
        chk("post_beat_cnt", {16'd0, beat_cnt}, 32'd0);
    endtask

    initial begin
        // K=2 matmul A=[[1,2],[3,4]] B=[[5,6],[7,8]]
        vt[0].k = 3'd2;
        vt[0].a0 = {8'd0, 8'd0, 8'd2, 8'd1};
        vt[0].a1 = {8'd0, 8'd0, 8'd4, 8'd3};
        vt[0].b0 = {8'd0, 8'd0, 8'd7, 8'd5};
        vt[0].b1 = {8'd0, 8'd0, 8'd8, 8'd6};
        vt[0].c  = {32'd50, 32'd43, 32'd22, 32'd19};
        vt[0].bp = 8'd0;
        // K=1 signed extremes a=(-128,127) b=(-128,-128), with backpressure
        vt[1].k = 3'd1;
        vt[1].a0 = {24'd0, 8'h80};
        vt[1].a1 = {24'd0, 8'h7f};
        vt[1].b0 = {24'd0, 8'h80};
        vt[1].b1 = {24'd0, 8'h80};
        vt[1].c  = {-32'sd16256, -32'sd16256, 32'd16384, 32'd16384};
        vt[1].bp = 8'd10;
        // K=3: beats a=(1,1)b=(1,1); a=(2,0)b=(3,4); a=(-1,5)b=(2,-3)
        vt[2].k = 3'd3;
        vt[2].a0 = {8'd0, 8'hff, 8'd2, 8'd1};
        vt[2].a1 = {8'd0, 8'd5, 8'd0, 8'd1};
        vt[2].b0 = {8'd0, 8'd2, 8'd3, 8'd1};
        vt[2].b1 = {8'd0, 8'hfd, 8'd4, 8'd1};
        vt[2].c  = {-32'sd14, 32'd11, 32'd12, 32'd5};
        vt[2].bp = 8'd2;
        // K=1 a=(2,2) b=(3,3) after the mid-tile reset
        vt[3].k = 3'd1;
        vt[3].a0 = {24'd0, 8'd2};
        vt[3].a1 = {24'd0, 8'd2};
        vt[3].b0 = {24'd0, 8'd3};
        vt[3].b1 = {24'd0, 8'd3};
        vt[3].c  = {32'd6, 32'd6, 32'd6, 32'd6};
        vt[3].bp = 8'd0;
        // K=1 a=(3,-2) b=(4,5) after a stray mac_out_valid
        vt[4].k = 3'd1;
        vt[4].a0 = {24'd0, 8'd3};
        vt[4].a1 = {24'd0, 8'hfe};
        vt[4].b0 = {24'd0, 8'd4};
        vt[4].b1 = {24'd0, 8'd5};
        vt[4].c  = {-32'sd10, -32'sd8, 32'd15, 32'd12};
        vt[4].bp = 8'd1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_in_valid", {31'd0, mac_in_valid}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_err", {31'd0, err_stray}, 32'd0);
        chk("rst_cnt", {16'd0, beat_cnt}, 32'd0);
        chk("rst_c00", res_c00, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back tiles from the table
        for (int t = 0; t < 3; t++) run_tile(vt[t]);
        chk("no_stray_yet", {31'd0, err_stray}, 32'd0);

        // Reset during WAIT of the second beat of a K=4 tile
        send_beat(8'd1, 8'd1, 8'd1, 8'd1, 1'b0, 1'b1);
        send_beat(8'd9, 8'd9, 8'd9, 8'd9, 1'b0, 1'b0);
        @(negedge clk);
        chk("mid_cnt", {16'd0, beat_cnt}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("mrst_in_valid", {31'd0, mac_in_valid}, 32'd0);
        chk("mrst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("mrst_cnt", {16'd0, beat_cnt}, 32'd0);
        chk("mrst_err", {31'd0, err_stray}, 32'd0);
        chk("mrst_a0", {24'd0, mac_a0}, 32'd0);
        chk("mrst_c00", res_c00, 32'd0);
        chk("mrst_c11", res_c11, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * LAT; i++) begin
            @(negedge clk);
            chk("mrst_no_result", {31'd0, res_valid}, 32'd0);
        end
        run_tile(vt[3]);

        // Stray mac_out_valid in IDLE
        @(posedge clk);
        #1 stray = 1'b1;
        @(posedge clk);
        #1 stray = 1'b0;
        @(negedge clk);
        chk("stray_set", {31'd0, err_stray}, 32'd1);
        chk("stray_cnt", {16'd0, beat_cnt}, 32'd0);
        chk("stray_c00", res_c00, 32'd6);
        repeat (5) @(negedge clk);
        chk("stray_sticky", {31'd0, err_stray}, 32'd1);
        run_tile(vt[4]);
        chk("stray_sticky_end", {31'd0, err_stray}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
